// File: rtl/line_prefetcher.sv
// line_prefetcher
//   Pixel source for VGA2monitor. Two line buffers alternate roles: one is
//   read for display while the next line is burst-fetched from SRAM (RGB565,
//   one pixel per word) into the other. A render request (H, V) returns the
//   RGB888 colour on o_color exactly two cycles later.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_H_to_be_rendered      requested column 1..H_SIZE, 0 = idle
//   i_V_to_be_rendered      requested line 1..V_SIZE
//   i_render_clk            high while the active region is requested
//   i_V_sync                active-low vertical sync
//   o_color                 RGB888 pixel, registered
//   o_sram_req/o_sram_addr  read request and word address
//   i_sram_gnt              request accepted (transfer when req && gnt)
//   i_sram_rdata/rvalid     in-order read data
//   o_underrun              sticky: late swap or frame start during a fetch
module line_prefetcher #(
    parameter int H_SIZE      = 1600,
    parameter int V_SIZE      = 900,
    parameter int MAP_H_WIDTH = 11,
    parameter int MAP_V_WIDTH = 10,
    parameter int ADDR_WIDTH  = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [MAP_H_WIDTH-1:0] i_H_to_be_rendered,
    input  logic [MAP_V_WIDTH-1:0] i_V_to_be_rendered,
    input  logic                   i_render_clk,
    input  logic                   i_V_sync,
    output logic [23:0]            o_color,
    output logic                   o_sram_req,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    input  logic                   i_sram_gnt,
    input  logic [15:0]            i_sram_rdata,
    input  logic                   i_sram_rvalid,
    output logic                   o_underrun
);

    localparam int CW = $clog2(H_SIZE + 1);
    localparam logic [CW-1:0] C_LAST = CW'(H_SIZE - 1);
    localparam logic [CW-1:0] C_FULL = CW'(H_SIZE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    endfunction

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic                   r_vsync_d1;
    logic                   r_vsync_d2;
    logic                   r_disp_buf;
    logic                   r_fill_buf;
    logic [ADDR_WIDTH-1:0]  r_line_base;
    logic [CW-1:0]          r_issue_cnt;
    logic [CW-1:0]          r_recv_cnt;
    logic                   r_underrun;
    logic [15:0]            r_buf0 [0:H_SIZE-1];
    logic [15:0]            r_buf1 [0:H_SIZE-1];
    logic [15:0]            r_rd_px;
    logic                   r_rd_black;
    logic [23:0]            r_color;

    logic                   w_frame_start;
    logic                   w_swap;
    logic                   w_more_lines;
    logic                   w_busy;
    logic                   w_frame_fetch;
    logic                   w_fetch_start;
    logic                   w_grant;
    logic                   w_wr_en;
    logic                   w_rd_black;
    logic                   w_rd_buf;
    logic [MAP_H_WIDTH-1:0] w_rd_idx;
    logic                   w_sram_req;
    logic [ADDR_WIDTH-1:0]  w_sram_addr;

    assign w_frame_start = r_vsync_d2 & ~r_vsync_d1;
    assign w_swap        = i_render_clk && (i_H_to_be_rendered == MAP_H_WIDTH'(1));
    assign w_more_lines  = i_V_to_be_rendered < MAP_V_WIDTH'(V_SIZE);
    assign w_busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
    // A frame start only launches a fetch when none is running; swap wins a tie.
    assign w_frame_fetch = w_frame_start && !w_swap && !w_busy;
    assign w_fetch_start = (w_swap && w_more_lines) || w_frame_fetch;
    assign w_grant       = (r_state == S_FETCH) && i_sram_gnt;
    // Rvalids outside an active fetch belong to an aborted burst and are dropped.
    assign w_wr_en       = i_sram_rvalid && w_busy && (r_recv_cnt != C_FULL) && !i_rst;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; swap and frame start override the burst sequencing.
    always_comb begin
        w_next_state = r_state;
        if (w_swap) begin
            if (w_more_lines) begin
                w_next_state = S_FETCH;
            end else begin
                w_next_state = S_IDLE;
            end
        end else if (w_frame_fetch) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_FETCH: begin
                    if (i_sram_gnt && (r_issue_cnt == C_LAST)) begin
                        w_next_state = S_DRAIN;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (r_recv_cnt == C_FULL) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_DRAIN;
                    end
                end
                S_DONE:  w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // FSM outputs: request while issuing, address is line base plus issue count.
    always_comb begin
        w_sram_req  = 1'b0;
        w_sram_addr = {ADDR_WIDTH{1'b0}};
        if (r_state == S_FETCH) begin
            w_sram_req  = 1'b1;
            w_sram_addr = r_line_base + ADDR_WIDTH'(r_issue_cnt);
        end else begin
            w_sram_req  = 1'b0;
            w_sram_addr = {ADDR_WIDTH{1'b0}};
        end
    end

    assign o_sram_req  = w_sram_req;
    assign o_sram_addr = w_sram_addr;

    // Control state: vsync edge detect, buffer roles, line base, counters, underrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync_d1  <= 1'b1;
            r_vsync_d2  <= 1'b1;
            r_disp_buf  <= 1'b1;
            r_fill_buf  <= 1'b0;
            r_line_base <= BASE_ADDR;
            r_issue_cnt <= {CW{1'b0}};
            r_recv_cnt  <= {CW{1'b0}};
            r_underrun  <= 1'b0;
        end else begin
            r_vsync_d1 <= i_V_sync;
            r_vsync_d2 <= r_vsync_d1;
            if (w_swap) begin
                r_disp_buf <= r_fill_buf;
                if (w_more_lines) begin
                    r_fill_buf  <= ~r_fill_buf;
                    r_line_base <= r_line_base + ADDR_WIDTH'(H_SIZE);
                end
            end else if (w_frame_fetch) begin
                r_fill_buf  <= 1'b0;
                r_line_base <= BASE_ADDR;
            end
            if (w_fetch_start) begin
                r_issue_cnt <= {CW{1'b0}};
                r_recv_cnt  <= {CW{1'b0}};
            end else begin
                if (w_grant) begin
                    r_issue_cnt <= r_issue_cnt + CW'(1);
                end
                if (w_wr_en) begin
                    r_recv_cnt <= r_recv_cnt + CW'(1);
                end
            end
            if ((w_swap && (r_state != S_DONE)) || (w_frame_start && !w_swap && w_busy)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Line buffer writes from returning SRAM data into the fill buffer.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !r_fill_buf) begin
            r_buf0[r_recv_cnt] <= i_sram_rdata;
        end
        if (w_wr_en && r_fill_buf) begin
            r_buf1[r_recv_cnt] <= i_sram_rdata;
        end
    end

    // Read address decode; on the swap cycle the new display buffer is already used.
    always_comb begin
        w_rd_black = (i_H_to_be_rendered == {MAP_H_WIDTH{1'b0}}) ||
                     (i_H_to_be_rendered > MAP_H_WIDTH'(H_SIZE));
        w_rd_buf   = w_swap ? r_fill_buf : r_disp_buf;
        if (w_rd_black) begin
            w_rd_idx = {MAP_H_WIDTH{1'b0}};
        end else begin
            w_rd_idx = i_H_to_be_rendered - MAP_H_WIDTH'(1);
        end
    end

    // Read stage 1: synchronous buffer read plus black flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_px    <= 16'h0000;
            r_rd_black <= 1'b1;
        end else begin
            r_rd_px    <= w_rd_buf ? r_buf1[w_rd_idx] : r_buf0[w_rd_idx];
            r_rd_black <= w_rd_black;
        end
    end

    // Read stage 2: RGB565 to RGB888 expansion into the output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_color <= 24'h000000;
        end else begin
            r_color <= r_rd_black ? 24'h000000 : rgb565_to_888(r_rd_px);
        end
    end

    assign o_color    = r_color;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_line_prefetcher.sv
module tb_line_prefetcher;

    localparam int H  = 1600;
    localparam int V  = 900;
    localparam int AW = 20;
    localparam logic [AW-1:0] BASE = 20'd0;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [10:0]   i_H = 11'd0;
    logic [9:0]    i_V = 10'd0;
    logic          i_render_clk = 1'b0;
    logic          i_V_sync = 1'b1;
    logic [23:0]   o_color;
    logic          o_sram_req;
    logic [AW-1:0] o_sram_addr;
    logic          i_sram_gnt = 1'b0;
    logic [15:0]   i_sram_rdata = 16'h0000;
    logic          i_sram_rvalid = 1'b0;
    logic          o_underrun;

    always #5 clk = ~clk;

    line_prefetcher #(
        .H_SIZE(H), .V_SIZE(V), .MAP_H_WIDTH(11), .MAP_V_WIDTH(10),
        .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_H_to_be_rendered(i_H), .i_V_to_be_rendered(i_V),
        .i_render_clk(i_render_clk), .i_V_sync(i_V_sync),
        .o_color(o_color), .o_sram_req(o_sram_req), .o_sram_addr(o_sram_addr),
        .i_sram_gnt(i_sram_gnt), .i_sram_rdata(i_sram_rdata),
        .i_sram_rvalid(i_sram_rvalid), .o_underrun(o_underrun)
    );

    typedef struct { int due; logic [23:0] col; int h; } exp_t;
    typedef struct { int due; logic [AW-1:0] addr; } rd_t;

    exp_t exp_q[$];
    rd_t  pend_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   gnt_mode = 0;
    bit   gap_en = 1'b0;
    int   iss_cnt [0:8191];
    int   iss_total = 0;
    int   first_addr = -1;
    int   wr_total = 0;
    int   disp_line = 0;
    int   fill_line = 1;

    function automatic logic [15:0] sram_word(input logic [AW-1:0] a);
        logic [31:0] t;
        if (a == BASE + 20'd4) return 16'hF800;
        if (a == BASE + 20'd1600) return 16'h07E0;
        t = 32'(a) * 32'd40503 + 32'd4951;
        return t[15:0];
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    function automatic int bad_addrs(input int base);
        int n = 0;
        for (int a = base; a < base + H; a++) begin
            if (iss_cnt[a] != 1) n++;
        end
        return n;
    endfunction

    // One clock: drive SRAM side, advance, then pop due pixel expectations.
    task automatic tick();
        rd_t  r;
        exp_t e;
        case (gnt_mode)
            0: i_sram_gnt = 1'b1;
            1: i_sram_gnt = ((cyc % 3) == 0);
            default: i_sram_gnt = 1'b0;
        endcase
        if (o_sram_req && i_sram_gnt && !i_rst) begin
            r.due  = cyc + 3;
            r.addr = o_sram_addr;
            pend_q.push_back(r);
            iss_total++;
            if (first_addr < 0) first_addr = int'(o_sram_addr);
            if (o_sram_addr < 20'd8192) iss_cnt[o_sram_addr[12:0]]++;
        end
        i_sram_rvalid = 1'b0;
        i_sram_rdata  = 16'h0000;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
            !(gap_en && $urandom_range(0, 2) == 0)) begin
            r = pend_q.pop_front();
            i_sram_rvalid = 1'b1;
            i_sram_rdata  = sram_word(r.addr);
            wr_total++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (o_color !== e.col) begin
                errors++;
                $display("FAIL pixel h=%0d line=%0d: got %h expected %h", e.h, disp_line, o_color, e.col);
            end
        end
    endtask

    // Drive a render request; when chk is set, queue its expected colour for T+2.
    task automatic set_req(input int h, input int v, input bit rc, input bit chk);
        exp_t e;
        i_H = 11'(h);
        i_V = 10'(v);
        i_render_clk = rc;
        if (rc && h == 1) begin
            disp_line = fill_line;
            if (v < V) fill_line++;
        end
        if (chk) begin
            e.due = cyc + 2;
            e.h   = h;
            if (h == 0 || h > H) e.col = 24'h000000;
            else e.col = expand(sram_word(BASE + 20'((disp_line - 1) * H + h - 1)));
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_track();
        for (int i = 0; i < 8192; i++) iss_cnt[i] = 0;
        iss_total  = 0;
        first_addr = -1;
        wr_total   = 0;
    endtask

    task automatic vsync_fall();
        i_V_sync = 1'b0;
        tick();
        i_V_sync = 1'b1;
        fill_line = 1;
    endtask

    task automatic wait_fetch(input int budget, output bit ok);
        int n = 0;
        while (!(iss_total >= H && pend_q.size() == 0 && !o_sram_req) && n < budget) begin
            tick();
            n++;
        end
        ok = (iss_total >= H && pend_q.size() == 0 && !o_sram_req);
        repeat (2) tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (4) tick();
        checks++; if (o_color !== 24'h0) begin errors++; $display("FAIL reset_color: got %h expected 000000", o_color); end
        checks++; if (o_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_sram_req); end
        checks++; if (o_sram_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", o_sram_addr); end
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", o_underrun); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_first_fetch();
        bit ok;
        int hi = 0;
        clear_track();
        gnt_mode = 0;
        gap_en = 1'b0;
        vsync_fall();
        wait_fetch(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fetch1_timeout: issued %0d expected %0d", iss_total, H); end
        checks++; if (first_addr != int'(BASE)) begin errors++; $display("FAIL fetch1_first: got %0d expected %0d", first_addr, BASE); end
        checks++; if (iss_total != H) begin errors++; $display("FAIL fetch1_count: got %0d expected %0d", iss_total, H); end
        checks++; if (bad_addrs(int'(BASE)) != 0) begin errors++; $display("FAIL fetch1_addrs: %0d bad got, 0 expected", bad_addrs(int'(BASE))); end
        checks++; if (wr_total != H) begin errors++; $display("FAIL fetch1_rvalids: got %0d expected %0d", wr_total, H); end
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL fetch1_underrun: got %b expected 0", o_underrun); end
        repeat (5) begin tick(); if (o_sram_req) hi++; end
        checks++; if (hi != 0) begin errors++; $display("FAIL fetch1_idle_req: got %0d req cycles expected 0", hi); end
    endtask

    task automatic test_display_line1();
        bit ok;
        clear_track();
        for (int h = 1; h <= H; h++) begin set_req(h, 1, 1'b1, 1'b1); tick(); end
        set_req(0, 1, 1'b0, 1'b1); tick();
        set_req(1700, 1, 1'b0, 1'b1); tick();
        set_req(0, 1, 1'b0, 1'b1); tick();
        tick();
        wait_fetch(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fetch2_timeout: issued %0d expected %0d", iss_total, H); end
        checks++; if (first_addr != int'(BASE) + H) begin errors++; $display("FAIL fetch2_first: got %0d expected %0d", first_addr, int'(BASE) + H); end
        checks++; if (bad_addrs(int'(BASE) + H) != 0) begin errors++; $display("FAIL fetch2_addrs: %0d bad got, 0 expected", bad_addrs(int'(BASE) + H)); end
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL line1_underrun: got %b expected 0", o_underrun); end
    endtask

    task automatic test_line2_gnt_pattern();
        bit ok;
        clear_track();
        gnt_mode = 1;
        gap_en = 1'b1;
        for (int h = 1; h <= 8; h++) begin set_req(h, 2, 1'b1, 1'b1); tick(); end
        set_req(H, 2, 1'b1, 1'b1); tick();
        set_req(0, 2, 1'b0, 1'b1); tick();
        wait_fetch(6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fetch3_timeout: issued %0d expected %0d", iss_total, H); end
        checks++; if (first_addr != int'(BASE) + 2 * H) begin errors++; $display("FAIL fetch3_first: got %0d expected %0d", first_addr, int'(BASE) + 2 * H); end
        checks++; if (iss_total != H) begin errors++; $display("FAIL fetch3_count: got %0d expected %0d", iss_total, H); end
        checks++; if (bad_addrs(int'(BASE) + 2 * H) != 0) begin errors++; $display("FAIL fetch3_addrs: %0d bad got, 0 expected", bad_addrs(int'(BASE) + 2 * H)); end
        checks++; if (wr_total != H) begin errors++; $display("FAIL fetch3_rvalids: got %0d expected %0d", wr_total, H); end
    endtask

    task automatic test_underrun();
        bit ok;
        gnt_mode = 2;
        gap_en = 1'b0;
        clear_track();
        for (int h = 1; h <= H; h++) begin set_req(h, 3, 1'b1, 1'b1); tick(); end
        set_req(0, 3, 1'b0, 1'b1); tick();
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL stall_underrun_early: got %b expected 0", o_underrun); end
        checks++; if (o_sram_req !== 1'b1 || iss_total != 0) begin errors++; $display("FAIL stall_req: got req=%b issued=%0d expected req=1 issued=0", o_sram_req, iss_total); end
        set_req(1, 4, 1'b1, 1'b0); tick();
        gnt_mode = 0;
        set_req(0, 4, 1'b0, 1'b1); tick();
        tick();
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", o_underrun); end
        wait_fetch(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fetch5_timeout: issued %0d expected %0d", iss_total, H); end
        checks++; if (first_addr != int'(BASE) + 4 * H) begin errors++; $display("FAIL fetch5_first: got %0d expected %0d", first_addr, int'(BASE) + 4 * H); end
        checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", o_underrun); end
    endtask

    task automatic test_last_line();
        bit ok;
        int hi = 0;
        int n = 0;
        set_req(1, V, 1'b1, 1'b0); tick();
        set_req(2, V, 1'b1, 1'b1); tick();
        set_req(0, V, 1'b0, 1'b1);
        repeat (5) begin tick(); if (o_sram_req) hi++; end
        checks++; if (hi != 0) begin errors++; $display("FAIL last_line_req: got %0d req cycles expected 0", hi); end
        clear_track();
        vsync_fall();
        while (iss_total < 100 && n < 300) begin tick(); n++; end
        checks++; if (first_addr != int'(BASE)) begin errors++; $display("FAIL refetch_first: got %0d expected %0d", first_addr, BASE); end
        i_rst = 1'b1;
        tick();
        checks++; if (o_sram_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", o_sram_req); end
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL rst_mid_underrun: got %b expected 0", o_underrun); end
        i_rst = 1'b0;
        hi = 0;
        repeat (20) begin tick(); if (o_sram_req) hi++; end
        checks++; if (hi != 0 || pend_q.size() != 0) begin errors++; $display("FAIL stale_rvalid: got %0d req cycles, %0d pending expected 0/0", hi, pend_q.size()); end
        clear_track();
        vsync_fall();
        wait_fetch(3000, ok);
        checks++; if (!ok || iss_total != H) begin errors++; $display("FAIL fetch_after_rst: issued %0d expected %0d", iss_total, H); end
        checks++; if (bad_addrs(int'(BASE)) != 0) begin errors++; $display("FAIL fetch_after_rst_addrs: %0d bad got, 0 expected", bad_addrs(int'(BASE))); end
        for (int h = 1; h <= 6; h++) begin set_req(h, 1, 1'b1, 1'b1); tick(); end
        set_req(0, 1, 1'b0, 1'b1);
        repeat (3) tick();
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL after_rst_underrun: got %b expected 0", o_underrun); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_display_line1();
        test_line2_gnt_pattern();
        test_underrun();
        test_last_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
